// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator that scans a 320x240 3-bit framebuffer
// with 2x2 pixel doubling, driving colour and syncs with a common two-pixel latency.
module vga_scanout #(
    parameter int CLK_DIV     = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int RAM_LATENCY = 1,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] fb_address,
    input  logic [2:0]  fb_read_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start,
    output logic        vblank
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL);
    typedef logic [DW-1:0] div_t;
    typedef logic [CW-1:0] cnt_t;
    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);
    localparam div_t RD_AT    = div_t'(RAM_LATENCY);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

    div_t        div_q, div_d;
    cnt_t        hcount_q, hcount_d, vcount_q, vcount_d;
    logic [18:0] fb_address_q, fb_address_d;
    logic        vis0_q, vis0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic [2:0]  rd_q, rd_d, rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d, vblank_q, vblank_d;
    logic        pe, h_wrap, v_wrap, visible;

    always_comb begin
        pe            = div_q == DIV_LAST;
        h_wrap        = hcount_q == H_LAST;
        v_wrap        = vcount_q == V_LAST;
        visible       = hcount_q < H_VIS && vcount_q < V_VIS;
        div_d         = pe ? '0 : div_q + div_t'(1);
        hcount_d      = pe ? (h_wrap ? '0 : hcount_q + cnt_t'(1)) : hcount_q;
        vcount_d      = (pe && h_wrap) ? (v_wrap ? '0 : vcount_q + cnt_t'(1)) : vcount_q;
        fb_address_d  = pe ? (visible ? 19'(vcount_q >> 1) * 19'd320 + 19'(hcount_q >> 1) : '0)
                           : fb_address_q;
        vis0_d        = pe ? visible : vis0_q;
        hs0_d         = pe ? (hcount_q >= HS_START && hcount_q < HS_END) : hs0_q;
        vs0_d         = pe ? (vcount_q >= VS_START && vcount_q < VS_END) : vs0_q;
        // Capture read data on the first clock it is valid; with the maximum latency that is the pe clock itself.
        rd_d          = div_q == RD_AT ? fb_read_data : rd_q;
        rgb_d         = pe ? (vis0_q ? rd_d : '0) : rgb_q;
        hsync_d       = pe ? (hs0_q ? SYNC_ACTIVE : ~SYNC_ACTIVE) : hsync_q;
        vsync_d       = pe ? (vs0_q ? SYNC_ACTIVE : ~SYNC_ACTIVE) : vsync_q;
        frame_start_d = pe && h_wrap && v_wrap;
        vblank_d      = pe ? vcount_d >= V_VIS : vblank_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            fb_address_q  <= '0;
            vis0_q        <= 1'b0;
            hs0_q         <= 1'b0;
            vs0_q         <= 1'b0;
            rd_q          <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            fb_address_q  <= fb_address_d;
            vis0_q        <= vis0_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            rd_q          <= rd_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end
    end

    assign fb_address  = fb_address_q;
    assign vga_r       = {4{rgb_q[2]}};
    assign vga_g       = {4{rgb_q[1]}};
    assign vga_b       = {4{rgb_q[0]}};
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized framebuffer scanout checked against a pixel-index arithmetic model,
// run with shrunken porches/visible area so several whole frames fit in a short simulation.
module tb_vga_scanout;
    localparam int CD = 2;
    localparam int HV = 40, HF = 4, HS = 6, HB = 4;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;
    localparam int MEMSZ = 320 * (VV / 2);
    localparam int AW = $clog2(MEMSZ);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] fb_address;
    logic [2:0]  fb_read_data = 3'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_start, vblank;
    logic [2:0]  mem [MEMSZ];
    int          total = 0;
    int          bad = 0;
    int          n = 0;

    vga_scanout #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RAM_LATENCY(1), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .fb_address(fb_address), .fb_read_data(fb_read_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_start(frame_start), .vblank(vblank)
    );

    always #5 clock = ~clock;

    // n = clock edges since reset release
    always @(posedge clock or posedge reset) n <= reset ? 0 : n + 1;

    always @(posedge clock)
        fb_read_data <= (int'(fb_address) < MEMSZ) ? mem[fb_address[AW-1:0]] : 3'b0;

    // Scan position (pixel index within frame) 'lag' pixel ticks behind the counters after edge nn.
    function automatic int pidx(int nn, int lag);
        return (nn / CD - lag) % (HT * VT);
    endfunction

    function automatic logic [11:0] exp_rgb(int nn);
        int q;
        logic [2:0] c;
        if (nn / CD < 2) return 12'h000;
        q = pidx(nn, 2);
        c = (q % HT < HV && q / HT < VV) ? mem[320 * (q / HT / 2) + (q % HT) / 2] : 3'b000;
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

    function automatic logic [1:0] exp_sync(int nn);
        int h, v;
        if (nn / CD < 2) return 2'b11;
        h = pidx(nn, 2) % HT;
        v = pidx(nn, 2) / HT;
        return {!(h >= HV + HF && h < HV + HF + HS), !(v >= VV + VF && v < VV + VF + VS)};
    endfunction

    function automatic int exp_addr(int nn);
        int h, v;
        if (nn / CD < 1) return 0;
        h = pidx(nn, 1) % HT;
        v = pidx(nn, 1) / HT;
        return (h < HV && v < VV) ? 320 * (v / 2) + h / 2 : 0;
    endfunction

    function automatic logic exp_fs(int nn);
        return nn > 0 && nn % CD == 0 && (nn / CD) % (HT * VT) == 0;
    endfunction

    function automatic logic exp_vb(int nn);
        return pidx(nn, 0) / HT >= VV;
    endfunction

    function automatic logic sig(int w);
        return w == 0 ? vga_hsync : w == 1 ? vga_vsync : w == 2 ? frame_start : vblank;
    endfunction

    task automatic wait_sig(input int w, input logic lvl, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (sig(w) === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 3'($urandom);
        repeat (5) @(negedge clock);
        total++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fb_address, frame_start, vblank} !==
            {12'h000, 2'b11, 19'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_values got rgb=%h hs=%b vs=%b addr=%0d fs=%b vb=%b want rgb=000 hs=1 vs=1 addr=0 fs=0 vb=0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fb_address, frame_start, vblank);
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        total++;
        if (fb_address !== 19'd0) begin
            bad++;
            $display("FAIL first_pe_addr0 got %0d want 0", fb_address);
        end
        @(negedge clock);
        total++;
        if (fb_address !== 19'd1) begin
            bad++;
            $display("FAIL first_pe_addr1 got %0d want 1", fb_address);
        end
    endtask

    task automatic test_free_run(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            total += 5;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n)) begin
                bad++;
                $display("FAIL free_run rgb n=%0d got %h want %h", n, {vga_r, vga_g, vga_b}, exp_rgb(n));
            end
            if ({vga_hsync, vga_vsync} !== exp_sync(n)) begin
                bad++;
                $display("FAIL free_run sync n=%0d got %b want %b", n, {vga_hsync, vga_vsync}, exp_sync(n));
            end
            if (fb_address !== 19'(exp_addr(n))) begin
                bad++;
                $display("FAIL free_run addr n=%0d got %0d want %0d", n, fb_address, exp_addr(n));
            end
            if (frame_start !== exp_fs(n)) begin
                bad++;
                $display("FAIL free_run frame_start n=%0d got %b want %b", n, frame_start, exp_fs(n));
            end
            if (vblank !== exp_vb(n)) begin
                bad++;
                $display("FAIL free_run vblank n=%0d got %b want %b", n, vblank, exp_vb(n));
            end
        end
    endtask

    task automatic test_hsync();
        bit ok1, ok2, ok3, ok4;
        int t0, t1, t2;
        wait_sig(0, 1'b1, FRAME, ok1);
        wait_sig(0, 1'b0, FRAME, ok2);
        t0 = n;
        wait_sig(0, 1'b1, FRAME, ok3);
        t1 = n;
        wait_sig(0, 1'b0, FRAME, ok4);
        t2 = n;
        total++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            bad++;
            $display("FAIL hsync_wait timeout got %b%b%b%b want 1111", ok1, ok2, ok3, ok4);
        end
        total++;
        if (t0 % (HT * CD) !== ((HV + HF + 2) * CD) % (HT * CD)) begin
            bad++;
            $display("FAIL hsync_fall_pos got %0d want %0d", t0 % (HT * CD), ((HV + HF + 2) * CD) % (HT * CD));
        end
        total++;
        if (t1 - t0 !== HS * CD) begin
            bad++;
            $display("FAIL hsync_width got %0d want %0d", t1 - t0, HS * CD);
        end
        total++;
        if (t2 - t0 !== HT * CD) begin
            bad++;
            $display("FAIL hsync_period got %0d want %0d", t2 - t0, HT * CD);
        end
    endtask

    task automatic test_frame_timing();
        bit ok;
        int vbc, vsl, fsc;
        vbc = 0;
        vsl = 0;
        fsc = 0;
        wait_sig(2, 1'b1, 2 * FRAME, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL frame_start_wait timeout got 0 want 1");
        end
        for (int k = 1; k < FRAME; k++) begin
            @(negedge clock);
            vbc += 32'(vblank);
            vsl += 32'(!vga_vsync);
            fsc += 32'(frame_start);
        end
        @(negedge clock);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_start_period got %b want 1 after %0d clocks", frame_start, FRAME);
        end
        total++;
        if (fsc !== 0) begin
            bad++;
            $display("FAIL frame_start_extra got %0d want 0", fsc);
        end
        total++;
        if (vbc !== (VT - VV) * HT * CD) begin
            bad++;
            $display("FAIL vblank_clocks got %0d want %0d", vbc, (VT - VV) * HT * CD);
        end
        total++;
        if (vsl !== VS * HT * CD) begin
            bad++;
            $display("FAIL vsync_low_clocks got %0d want %0d", vsl, VS * HT * CD);
        end
    endtask

    task automatic test_colour();
        int red, white;
        red = 0;
        white = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 3'b000;
        mem[320 * (VV / 4) + HV / 4] = 3'b100;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < FRAME + 4 * CD; k++) begin
            @(negedge clock);
            red += 32'({vga_r, vga_g, vga_b} === 12'hF00);
            total++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n)) begin
                bad++;
                $display("FAIL colour_red rgb n=%0d got %h want %h", n, {vga_r, vga_g, vga_b}, exp_rgb(n));
            end
        end
        total++;
        if (red !== 4 * CD) begin
            bad++;
            $display("FAIL colour_red_count got %0d want %0d", red, 4 * CD);
        end
        reset = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 3'b111;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clock);
            white += 32'({vga_r, vga_g, vga_b} === 12'hFFF);
            total++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n)) begin
                bad++;
                $display("FAIL colour_blank rgb n=%0d got %h want %h", n, {vga_r, vga_g, vga_b}, exp_rgb(n));
            end
        end
        total++;
        if (white !== HV * VV * CD) begin
            bad++;
            $display("FAIL colour_white_count got %0d want %0d", white, HV * VV * CD);
        end
    endtask

    task automatic test_reset_mid();
        bit found, ok;
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clock);
            if (pidx(n, 0) / HT == VV / 2 && pidx(n, 0) % HT == HV / 2) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || fb_address === 19'd0) begin
            bad++;
            $display("FAIL reset_mid_setup got found=%b addr=%0d want found=1 addr!=0", found, fb_address);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fb_address, frame_start, vblank} !==
            {12'h000, 2'b11, 19'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_mid_async got rgb=%h hs=%b vs=%b addr=%0d fs=%b vb=%b want 000 1 1 0 0 0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fb_address, frame_start, vblank);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        wait_sig(2, 1'b1, FRAME + 10, ok);
        total++;
        if (!ok || n !== FRAME) begin
            bad++;
            $display("FAIL reset_mid_restart got ok=%b edge=%0d want ok=1 edge=%0d", ok, n, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_free_run(2 * FRAME + int'($urandom_range(0, 500)));
        test_hsync();
        test_frame_timing();
        test_colour();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream display stage for the tron framebuffer (320x240, 3-bit colour per pixel, 19-bit address = 320*y + x).
- Owns the framebuffer read port: generates 640x480@60 VGA timing, doubles each framebuffer pixel 2x2, fetches pixel data and drives RGB/sync pins with sync and colour aligned.
- Also exports a frame-start pulse and a vertical-blank level for frame-synchronous logic.

Parameters:
- CLK_DIV, 2, system clocks per pixel; pixel-enable asserts once every CLK_DIV clocks.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, active lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- RAM_LATENCY, 1, framebuffer read latency in clocks; legal range 0..CLK_DIV-1.
- SYNC_ACTIVE, 0, asserted level of hsync/vsync.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- fb_address  out  19  framebuffer read address
- fb_read_data  in  3  framebuffer read data, valid RAM_LATENCY clocks after fb_address changes
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- frame_start  out  1  one-clock pulse at start of each frame
- vblank  out  1  high while vcount >= V_VISIBLE

Behaviour:
- Reset values, asynchronous: div counter 0, hcount 0, vcount 0, fb_address 0, vga_r/g/b 0, hsync/vsync = ~SYNC_ACTIVE, frame_start 0, vblank 0, all pipeline registers cleared.
- Pixel enable (pe):
  - Div counter counts 0..CLK_DIV-1, wraps to 0.
  - pe is high on clocks where the counter == CLK_DIV-1.
  - All timing state advances only on pe edges.
- Counters:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
  - hcount counts 0..H_TOTAL-1. On wrap, hcount goes to 0 and vcount increments.
  - vcount wraps 0 after V_TOTAL-1, on the same pe as the hcount wrap.
- Stage 0, on pe, registered:
  - fb_address = 320*(vcount>>1) + (hcount>>1) when hcount < H_VISIBLE and vcount < V_VISIBLE, else 0.
  - Latch into stage-0 registers: visible flag, raw hsync (H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC), raw vsync (same rule on vcount with V terms).
  - Arithmetic is 19-bit unsigned. Maximum address is 76799; the address never exceeds it.
- Stage 1, on the next pe, registered:
  - Sample fb_read_data. Guaranteed valid because RAM_LATENCY <= CLK_DIV-1.
  - If stage-0 visible: vga_r = {4{d[2]}}, vga_g = {4{d[1]}}, vga_b = {4{d[0]}}.
  - Otherwise RGB = 0.
  - vga_hsync/vga_vsync = stage-0 raw sync XNOR SYNC_ACTIVE, i.e. drive SYNC_ACTIVE when raw is 1.
- Resulting latency: counters to pins = 2 pe ticks, identical for colour and syncs, so there is no relative skew.
- Colour mapping examples: 3'b100 -> R=F,G=0,B=0; 3'b010 green; 3'b011 cyan; 3'b110 yellow; 3'b111 white; 3'b000 black.
- frame_start: high for exactly one clock, on the pe edge where the counters transition to hcount=0, vcount=0. It does not pulse on the first frame after reset (counters start at 0 without a transition).
- vblank: registered on pe from the next vcount value. It stays high across every whole line with vcount >= V_VISIBLE.
- Reset mid-frame: all outputs return to reset values immediately. After release, scanout restarts at (0,0) on the first pe; no partial-line state survives.
- Read-only: the block never writes the framebuffer, and fb_address is held stable between pe edges.

Test Plan:
- Reset asserted 5 clocks, then released -> during reset RGB=0, hsync=vsync=1, fb_address=0. First pe occurs at clock CLK_DIV after release; frame_start stays 0 until the first wrap.
- Free run, defaults -> hsync low for 192 clocks (96 pixels), period 1600 clocks. The falling edge appears 2 pe ticks after hcount reaches 656.
- Free run, full frame -> vsync low for 2 lines (rows 490-491), frame_start period 840000 clocks, vblank high for exactly 45 lines per frame.
- Addressing -> at (h,v)=(0,0),(1,1),(2,0),(639,479), fb_address = 0, 0, 1, 76799. With h>=640, fb_address=0.
- Colour path: RAM model returns 3'b100 at address 320*120+20 and 0 elsewhere -> pixels (40..41, 240..241) show R=F,G=0,B=0, everything else black. Data 3'b111 during h=700 -> RGB=0 (blanked).
- Pulse reset at v=300 mid-line -> outputs reset immediately; after release, the next frame_start occurs exactly 840000 clocks after the first pe.
